pwm_multi_msdsl: RTL
====================

Name: pwm_multi_msdsl

Overview:
Multi-channel digital PWM generator for emulation-time stimulus and switching-converter models.
- One shared period counter, advanced only on emulator step enable `cke`.
- N channels, each with its own duty and phase offset; registered outputs plus one-cycle rising/falling edge strobes.
- Period/duty/phase updates are double-buffered and commit only at a period wrap, so no channel ever sees a glitched cycle.

Parameters:
N, 4, number of PWM channels (1..32)
W, 16, width of period/duty/phase/counter in ticks (2..32)
PERIOD_INIT, 100, active period after reset (1..2^W-1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
cke  in  1  step enable; counter advances only when 1
period  in  W  requested period in ticks
duty  in  N*W  requested duty per channel, channel k at [k*W +: W]
phase  in  N*W  requested phase offset per channel, same packing
load  in  1  capture period/duty/phase into shadow and arm commit
pending  out  1  shadow values captured, awaiting commit
wrap  out  1  one-cycle pulse on counter wrap
out  out  N  PWM outputs, registered
rise  out  N  one-cycle pulse when out[k] goes 0->1
fall  out  N  one-cycle pulse when out[k] goes 1->0

Behaviour:
Reset (rst=0, asynchronous):
- cnt=0, active period=PERIOD_INIT, active duty=0 and phase=0 for all channels.
- Shadow registers=0, pending=0, wrap=0, out=0, rise=0, fall=0.

Effective period P:
- P = active period; P=0 is treated as 1.

Counter:
- On a clk edge with cke=1: if cnt==P-1, cnt<=0 and the cycle is a wrap event; else cnt<=cnt+1.
- cke=0: cnt holds.
- wrap is registered: it is 1 in the cycle after the wrap event, 0 otherwise.

Load/commit:
- load=1 at a clk edge: shadow<=inputs and pending<=1 (re-load overwrites the shadow).
- At a wrap event with pending=1: active<=shadow and pending<=0.
- load=1 in the same cycle as a wrap event: the inputs presented that cycle are committed directly to active; pending stays 0.
- Commit clamp: any phase[k] >= committed period is stored as 0.

Channel logic (combinational on current cnt and active regs):
- loc = cnt+phase[k]; if loc >= P then loc -= P. Use a W+1-bit sum; no divider.
- nxt[k] = (loc < duty[k]).
- duty[k]=0 gives constant 0; duty[k] >= P gives constant 1.

Output registers:
- out[k]<=nxt[k] every clk, regardless of cke, so outputs lag cnt by 1 cycle.
- rise[k]<=nxt[k]&~out[k]; fall[k]<=~nxt[k]&out[k].
- rise and fall are never both 1 for the same channel.

Period changes:
- Counter is always 0 immediately after a commit, so shrinking the period can never strand cnt above P-1.

Reset mid-operation:
- All state returns to reset values immediately.
- A pending load is discarded.
- The first clk after release evaluates with active duty=0, so out stays 0 until a load commits.

Width rules:
- All comparisons unsigned W-bit.
- Counter wrap never overflows because P <= 2^W-1.

Test Plan:
1. Reset release, cke=1 every cycle, default params -> out=0 for 300 cycles; wrap pulses every 100 cycles (first wrap pulse 100 cycles after release).
2. load with period=10, duty[0]=3, phase[0]=0 while cnt=5 -> pending=1 until cnt wraps; then out[0] is high 3 of every 10 cycles; rise[0] pulses once per period, 1 cycle after cnt==0.
3. period=10, duty[1]=5, phase[1]=7 -> out[1] high while cnt in {3,4,5,6,7}, i.e. rising when cnt goes 3 (observed one cycle later); phase=12 loaded -> stored as 0.
4. cke toggling 1,0,1,0 with period=4, duty=2 -> counter and out advance only on cke=1 cycles; a full period spans 8 clks; wrap is a single-clk pulse.
5. load asserted exactly on the wrap event cycle with duty[2]=10 >= period=10 -> committed same cycle, pending never rises, out[2] goes constant 1 with one rise pulse and no fall.
6. Assert rst mid-period with pending=1 -> out, rise, fall, wrap and pending drop to 0 asynchronously; after release the old shadow is not committed at the next wrap.

Source files
------------

// File: rtl/pwm_multi_msdsl.sv
// Multi-channel PWM generator. All channels share one period counter that advances on cke.
// Period, duty and phase updates are double-buffered and take effect only at a counter wrap.
module pwm_multi_msdsl #(
  parameter int N           = 4,
  parameter int W           = 16,
  parameter int PERIOD_INIT = 100
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cke,
  input  logic [W-1:0]   period,
  input  logic [N*W-1:0] duty,
  input  logic [N*W-1:0] phase,
  input  logic           load,
  output logic           pending,
  output logic           wrap,
  output logic [N-1:0]   out,
  output logic [N-1:0]   rise,
  output logic [N-1:0]   fall
);

  logic [W-1:0] cnt;
  logic [W-1:0] period_act;
  logic [W-1:0] period_sh;
  logic [W-1:0] duty_act  [N];
  logic [W-1:0] phase_act [N];
  logic [W-1:0] duty_sh   [N];
  logic [W-1:0] phase_sh  [N];
  logic [W-1:0] per_eff;
  logic         wrap_ev;
  logic [N-1:0] nxt_p0;

  // A phase at or beyond the new period would break the single-subtract wrap.
  function automatic logic [W-1:0] clamp_phase(input logic [W-1:0] ph, input logic [W-1:0] per);
    return (ph >= per) ? '0 : ph;
  endfunction

  assign per_eff = (period_act == '0) ? W'(1) : period_act;
  assign wrap_ev = cke && (cnt == per_eff - W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      wrap       <= 1'b0;
      pending    <= 1'b0;
      period_act <= W'(PERIOD_INIT);
      period_sh  <= '0;
      for (int k = 0; k < N; k++) begin
        duty_act[k]  <= '0;
        phase_act[k] <= '0;
        duty_sh[k]   <= '0;
        phase_sh[k]  <= '0;
      end
    end else begin
      wrap <= wrap_ev;
      if (cke) cnt <= wrap_ev ? '0 : cnt + W'(1);
      if (wrap_ev && load) begin
        period_act <= period;
        for (int k = 0; k < N; k++) begin
          duty_act[k]  <= duty[k*W +: W];
          phase_act[k] <= clamp_phase(phase[k*W +: W], period);
        end
        pending <= 1'b0;
      end else if (wrap_ev && pending) begin
        period_act <= period_sh;
        for (int k = 0; k < N; k++) begin
          duty_act[k]  <= duty_sh[k];
          phase_act[k] <= clamp_phase(phase_sh[k], period_sh);
        end
        pending <= 1'b0;
      end else if (load) begin
        period_sh <= period;
        for (int k = 0; k < N; k++) begin
          duty_sh[k]  <= duty[k*W +: W];
          phase_sh[k] <= phase[k*W +: W];
        end
        pending <= 1'b1;
      end
    end
  end

  // Stage p0: per-channel compare on the live counter, sum kept at W+1 bits
  for (genvar k = 0; k < N; k++) begin : g_ch
    logic [W:0]   sum;
    logic [W:0]   diff;
    logic [W-1:0] loc;
    assign sum        = {1'b0, cnt} + {1'b0, phase_act[k]};
    assign diff       = sum - {1'b0, per_eff};
    assign loc        = (sum >= {1'b0, per_eff}) ? diff[W-1:0] : sum[W-1:0];
    assign nxt_p0[k]  = (loc < duty_act[k]);
  end

  // Stage p1: registered outputs and edge strobes, updated every clk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out  <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      out  <= nxt_p0;
      rise <= nxt_p0 & ~out;
      fall <= ~nxt_p0 & out;
    end
  end

endmodule
